stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Sequencer and two-port arbiter for the 8-bit, 32-entry hardware stack in the multicycle CPU. Two requesters share the stack: port 0 is the datapath and port 1 is the call/interrupt unit. The block arbitrates round-robin, blocks overflow and underflow, drives the stack's push/pop/tos strobes for exactly one cycle, tracks occupancy, and returns read data with a done/err handshake.

## Interface
- DEPTH, 32, stack entries
- W, 8, data width
- CW, 6, count width (must hold 0..DEPTH)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request; hold with op/wdata stable until done
- op0 / op1  in  2  01=PUSH, 10=POP, 11=TOS, 00=illegal
- wdata0 / wdata1  in  W  push data
- gnt0 / gnt1  out  1  high during the CMD cycle of that port's transaction
- done0 / done1  out  1  one-cycle completion pulse (RESP cycle)
- err0 / err1  out  1  high with done when op was illegal, push on full, or pop/tos on empty
- rdata  out  W  equals stk_dout; valid in the done cycle of a successful POP/TOS
- count  out  CW  current occupancy
- full / empty  out  1  count==DEPTH / count==0
- stk_din  out  W  to stack din
- stk_push / stk_pop / stk_tos  out  1  one-cycle stack strobes, mutually exclusive
- stk_dout  in  W  stack dout (updated at the edge ending a pop/tos cycle)

## Operation
- FSM has three states:
  - IDLE: arbitrate among asserted reqs. On any grant, latch port, op and wdata, then go to CMD.
  - CMD: drive gnt of the latched port. Assert the matching strobe only if the op is legal, then go to RESP.
  - RESP: pulse done (and err if the op was rejected), then go to IDLE.
- Legality is checked in IDLE against the count value before the grant:
  - PUSH requires count<DEPTH.
  - POP and TOS require count>0.
  - op 00 is always illegal.
- A rejected transaction still takes CMD and RESP, but all strobes stay 0 and count is unchanged.
- Count updates at the edge ending CMD:
  - +1 on a legal PUSH.
  - −1 on a legal POP.
  - TOS leaves count unchanged.
- Count never wraps. The stack's own 5-bit pointer is never allowed to wrap.
- stk_din is driven with the latched wdata during CMD and holds its last value otherwise.
- Arbitration is round-robin:
  - The pointer names the preferred port and flips to the other port after every grant, including rejected ones.
  - With a single requester, that port is granted regardless of the pointer.
- Dropping req after a grant does not abort the transaction. It completes normally.
- The stack instance's active-high reset is tied to ~rst at the top level, so count and the stack top reset together.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state=IDLE and pointer=port 0.
  - count=0, empty=1, full=0.
  - gnt, done, err and all strobes = 0.
  - stk_din=0.
- Reset asserted mid-transaction drops all strobes and pulses immediately. No done is issued for the aborted transaction.
- Transaction timeline (req sampled high at edge E0):
  - CMD occupies E0→E1. The strobe is high in this cycle.
  - RESP occupies E1→E2. done, err and rdata are valid in this cycle.
  - IDLE occupies E2→E3 and samples the next req at E3.
- Throughput is one transaction per 3 cycles.
- POP/TOS read data appears on stk_dout at E1 and is presented as rdata during RESP.

## Test plan
- **Reset:** hold rst=0 for 2 cycles, then release. Expect count=0, empty=1, full=0, all gnt/done/err/strobes 0. Assert rst=0 during a CMD cycle; strobes must drop the same cycle and count must read 0.
- **Push/pop round trip:** port 0 PUSH 0x5A. Expect stk_push high exactly 1 cycle, stk_din=0x5A, count=1 after E1, done0 at cycle 2. Then POP: rdata=0x5A with done0, count=0, empty=1.
- **Underflow:** POP on empty from port 1. Expect done1=err1=1, stk_pop never asserted, count stays 0. Repeat with op=00 and expect the same err behaviour.
- **Overflow:** 32 PUSHes of 0x00..0x1F. Expect full=1, count=32. The 33rd PUSH 0xFF gets err, no stk_push, count stays 32. TOS then returns 0x1F.
- **Arbitration:** req0 and req1 both held high with PUSH after reset. Grants alternate 0,1,0,1. Each gnt appears in its own CMD cycle, 3 cycles apart, and never both at once.
- **Mixed ops:** push A1, A2, A3. TOS returns A3 with count still 3. Two POPs return A3 then A2. Final count=1.

Source files
------------

// File: rtl/stack_ctrl.sv
// Round-robin two-port sequencer for the CPU's 32-entry hardware stack.
// Each accepted request runs IDLE -> CMD (strobe) -> RESP (done/err), one transaction per 3 cycles.
module stack_ctrl #(
    parameter int DEPTH = 32,
    parameter int W     = 8,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [1:0]    op0,
    input  logic [1:0]    op1,
    input  logic [W-1:0]  wdata0,
    input  logic [W-1:0]  wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err0,
    output logic          err1,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic [W-1:0]  stk_din,
    output logic          stk_push,
    output logic          stk_pop,
    output logic          stk_tos,
    input  logic [W-1:0]  stk_dout,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0]    OP_PUSH  = 2'b01;
    localparam logic [1:0]    OP_POP   = 2'b10;
    localparam logic [1:0]    OP_TOS   = 2'b11;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        ptr;
    logic        port_q;
    logic [1:0]  op_q;
    logic        legal_q;

    logic        any_req;
    logic        sel_port;
    logic [1:0]  sel_op;
    logic [W-1:0] sel_wdata;
    logic        sel_legal;

    // Arbitration and legality, judged against the count before the grant.
    always_comb begin
        any_req   = req0 | req1;
        sel_port  = (req0 && req1) ? ptr : req1;
        sel_op    = sel_port ? op1 : op0;
        sel_wdata = sel_port ? wdata1 : wdata0;
        case (sel_op)
            OP_PUSH:        sel_legal = (count < FULL_CNT);
            OP_POP, OP_TOS: sel_legal = (count != '0);
            default:        sel_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = CMD;
            CMD:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        err0     = 1'b0;
        err1     = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_tos  = 1'b0;
        if (state == CMD) begin
            gnt0     = !port_q;
            gnt1     = port_q;
            stk_push = legal_q && (op_q == OP_PUSH);
            stk_pop  = legal_q && (op_q == OP_POP);
            stk_tos  = legal_q && (op_q == OP_TOS);
        end else if (state == RESP) begin
            done0 = !port_q;
            done1 = port_q;
            err0  = !port_q && !legal_q;
            err1  = port_q && !legal_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            port_q  <= 1'b0;
            op_q    <= 2'b00;
            legal_q <= 1'b0;
            stk_din <= '0;
            count   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                ptr     <= ~sel_port;
                port_q  <= sel_port;
                op_q    <= sel_op;
                legal_q <= sel_legal;
                stk_din <= sel_wdata;
            end
            // Legality guarantees count never wraps and the stack pointer stays in range.
            if (state == CMD && legal_q) begin
                if (op_q == OP_PUSH)
                    count <= count + CW'(1);
                else if (op_q == OP_POP)
                    count <= count - CW'(1);
            end
        end
    end

    assign rdata     = stk_dout;
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign dbg_state = state;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural 32x8 stack behind the strobes.
// Vector table covers the single-port op mix; hand sequences cover overflow, arbitration and resets.
module tb_stack_ctrl;

    localparam int DEPTH = 32;
    localparam int W     = 8;
    localparam int CW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [1:0]    op0, op1;
    logic [W-1:0]  wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, err0, err1;
    logic [W-1:0]  rdata;
    logic [CW-1:0] count;
    logic          full, empty;
    logic [W-1:0]  stk_din;
    logic          stk_push, stk_pop, stk_tos;
    logic [W-1:0]  stk_dout;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stack_ctrl #(.DEPTH(DEPTH), .W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata(rdata), .count(count),
        .full(full), .empty(empty), .stk_din(stk_din),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos),
        .stk_dout(stk_dout), .dbg_state(dbg_state)
    );

    // Behavioural stack: reset with ~rst, dout updates at the edge ending pop/tos.
    logic [W-1:0] mem [DEPTH];
    logic [5:0]   sp;
    logic [4:0]   top_idx;
    assign top_idx = sp[4:0] - 5'd1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp       <= '0;
            stk_dout <= '0;
        end else if (stk_push) begin
            mem[sp[4:0]] <= stk_din;
            sp           <= sp + 6'd1;
        end else if (stk_pop) begin
            stk_dout <= mem[top_idx];
            sp       <= sp - 6'd1;
        end else if (stk_tos) begin
            stk_dout <= mem[top_idx];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // One transaction on a single port; checks CMD and RESP cycles.
    task automatic run_txn(input logic port, input logic [1:0] op, input logic [W-1:0] wd,
                           input logic exp_err, input logic chk_rd, input logic [W-1:0] exp_rd,
                           input int exp_cnt, input string tag);
        logic got;
        logic [2:0] exp_strb;
        got = 1'b0;
        exp_strb = exp_err ? 3'b000 :
                   (op == 2'b01) ? 3'b100 : (op == 2'b10) ? 3'b010 : 3'b001;
        if (port) begin req1 = 1'b1; op1 = op; wdata1 = wd; end
        else      begin req0 = 1'b1; op0 = op; wdata0 = wd; end
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (port ? gnt1 : gnt0) got = 1'b1;
        end
        if (!got) begin
            check({tag, ".gnt_timeout"}, 0, 1);
            drop_reqs();
            return;
        end
        check({tag, ".gnt"},   {gnt1, gnt0}, port ? 2 : 1);
        check({tag, ".strb"},  {stk_push, stk_pop, stk_tos}, exp_strb);
        check({tag, ".early_done"}, {done1, done0}, 0);
        if (exp_strb == 3'b100) check({tag, ".din"}, stk_din, wd);
        @(posedge clk); #1;
        check({tag, ".done"},  {done1, done0}, port ? 2 : 1);
        check({tag, ".err"},   {err1, err0}, exp_err ? (port ? 2 : 1) : 0);
        check({tag, ".strb_off"}, {stk_push, stk_pop, stk_tos, gnt1, gnt0}, 0);
        if (chk_rd) check({tag, ".rdata"}, rdata, exp_rd);
        check({tag, ".count"}, count, exp_cnt);
        check({tag, ".flags"}, {full, empty}, {exp_cnt == DEPTH, exp_cnt == 0});
        drop_reqs();
    endtask

    typedef struct {
        logic         port;
        logic [1:0]   op;
        logic [W-1:0] wdata;
        logic         exp_err;
        logic         chk_rd;
        logic [W-1:0] exp_rd;
        int           exp_cnt;
    } vec_t;

    vec_t vecs [12];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drop_reqs();
        repeat (2) @(posedge clk);
        #1;
        check("rst.count", count, 0);
        check("rst.flags", {full, empty}, 2'b01);
        check("rst.outs", {gnt1, gnt0, done1, done0, err1, err0, stk_push, stk_pop, stk_tos}, 0);
        check("rst.din", stk_din, 0);
        check("rst.state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gport [4];
        int gcyc  [4];
        int ng;
        int both;
        int ndone;
        logic got;

        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'b00; op1 = 2'b00;
        wdata0 = '0; wdata1 = '0;

        //             port  op     wdata  err   chk   rd     cnt
        vecs[0]  = '{1'b0, 2'b01, 8'h5A, 1'b0, 1'b0, 8'h00, 1};
        vecs[1]  = '{1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 8'h5A, 0};
        vecs[2]  = '{1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 8'h00, 0};
        vecs[3]  = '{1'b1, 2'b00, 8'h33, 1'b1, 1'b0, 8'h00, 0};
        vecs[4]  = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b0, 8'h00, 0};
        vecs[5]  = '{1'b0, 2'b01, 8'hA1, 1'b0, 1'b0, 8'h00, 1};
        vecs[6]  = '{1'b0, 2'b01, 8'hA2, 1'b0, 1'b0, 8'h00, 2};
        vecs[7]  = '{1'b1, 2'b01, 8'hA3, 1'b0, 1'b0, 8'h00, 3};
        vecs[8]  = '{1'b1, 2'b11, 8'h00, 1'b0, 1'b1, 8'hA3, 3};
        vecs[9]  = '{1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 8'hA3, 2};
        vecs[10] = '{1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 8'hA2, 1};
        vecs[11] = '{1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 8'hA1, 0};

        do_reset();
        @(posedge clk); #1;
        check("post_rst.outs", {gnt1, gnt0, done1, done0, stk_push, stk_pop, stk_tos}, 0);
        check("post_rst.count", count, 0);

        foreach (vecs[i])
            run_txn(vecs[i].port, vecs[i].op, vecs[i].wdata, vecs[i].exp_err,
                    vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_cnt, $sformatf("vec%0d", i));

        // Fill to full, then overflow push and TOS on the full stack.
        for (int i = 0; i < DEPTH; i++)
            run_txn(1'b0, 2'b01, W'(i), 1'b0, 1'b0, 8'h00, i + 1, $sformatf("fill%0d", i));
        check("fill.full", full, 1);
        run_txn(1'b1, 2'b01, 8'hFF, 1'b1, 1'b0, 8'h00, DEPTH, "overflow");
        run_txn(1'b0, 2'b11, 8'h00, 1'b0, 1'b1, 8'h1F, DEPTH, "tos_full");

        // Both ports held with PUSH: grants alternate 0,1,0,1, three cycles apart.
        do_reset();
        ng = 0;
        both = 0;
        req0 = 1'b1; op0 = 2'b01; wdata0 = 8'h10;
        req1 = 1'b1; op1 = 2'b01; wdata1 = 8'h20;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            @(posedge clk); #1;
            if (gnt0 && gnt1) both++;
            if (gnt0 || gnt1) begin
                gport[ng] = gnt1 ? 1 : 0;
                gcyc[ng]  = c;
                ng++;
            end
        end
        @(posedge clk); #1;
        drop_reqs();
        check("arb.ngrants", ng, 4);
        check("arb.both", both, 0);
        for (int i = 0; i < ng; i++) begin
            check($sformatf("arb.port%0d", i), gport[i], i % 2);
            if (i > 0) check($sformatf("arb.gap%0d", i), gcyc[i] - gcyc[i-1], 3);
        end
        @(posedge clk); #1;
        check("arb.count", count, 4);

        // Reset asserted in the middle of a CMD cycle.
        got = 1'b0;
        req0 = 1'b1; op0 = 2'b01; wdata0 = 8'h77;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (gnt0) got = 1'b1;
        end
        check("midrst.gnt_seen", got, 1);
        check("midrst.push_before", stk_push, 1);
        rst = 1'b0;
        drop_reqs();
        #1;
        check("midrst.outs", {gnt1, gnt0, done1, done0, err1, err0, stk_push, stk_pop, stk_tos}, 0);
        check("midrst.count", count, 0);
        check("midrst.empty", empty, 1);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done0 || done1 || stk_push) ndone++;
        end
        check("midrst.no_done", ndone, 0);
        check("midrst.count_after", count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
